// File: rtl/spi_shift_mlane_pkg.sv
// Shared types and defaults for the multi-lane SPI character shifter.
package spi_shift_mlane_pkg;

    localparam int unsigned MaxCharDefault = 32;
    localparam int unsigned DivWDefault    = 16;

    typedef enum logic [1:0] {
        ModeSingle = 2'b00,
        ModeDual   = 2'b01,
        ModeQuad   = 2'b10,
        ModeRsvd   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // log2 of the lane count; the reserved code maps to one lane but is rejected anyway
    function automatic logic [1:0] lane_log2(input logic [1:0] mode);
        case (mode)
            2'b01:   return 2'd1;
            2'b10:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_shift_mlane_sclk_gen.sv
// SCLK divider: one edge strobe every divider+1 cycles while running, alternating
// leading/trailing, with sclk_o toggling on each strobe and reloaded to the idle level on load.
module spi_shift_mlane_sclk_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             load_lvl,
    input  logic             run,
    input  logic [DIV_W-1:0] divider,
    output logic             sclk_o,
    output logic             lead,
    output logic             trail
);

    logic [DIV_W-1:0] cnt_q;
    logic             phase_q;
    logic             sclk_q;
    logic             strobe;

    assign strobe = run && (cnt_q == divider);
    assign lead   = strobe && !phase_q;
    assign trail  = strobe && phase_q;
    assign sclk_o = sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            sclk_q  <= 1'b0;
        end else if (load) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            sclk_q  <= load_lvl;
        end else if (run) begin
            if (strobe) begin
                cnt_q   <= '0;
                phase_q <= !phase_q;
                sclk_q  <= !sclk_q;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_shift_mlane.sv
// SPI character shifter over 1, 2 or 4 lanes with CPOL/CPHA modes, valid/ready char
// interface towards the register front-end and sclk/lane pins towards the pads.
module spi_shift_mlane
    import spi_shift_mlane_pkg::*;
#(
    parameter int unsigned MAX_CHAR = MaxCharDefault,
    parameter int unsigned LEN_W    = $clog2(MAX_CHAR),
    parameter int unsigned DIV_W    = DivWDefault
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [MAX_CHAR-1:0] tx_data,
    input  logic [LEN_W-1:0]    len,
    input  logic [1:0]          mode,
    input  logic                dir,
    input  logic                lsb,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [DIV_W-1:0]    divider,
    input  logic                abort,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [MAX_CHAR-1:0] rx_data,
    output logic                cfg_err,
    output logic                tip,
    output logic                sclk_o,
    output logic [3:0]          sd_o,
    output logic [3:0]          sd_oe,
    input  logic [3:0]          sd_i
);

    localparam int unsigned BW = LEN_W + 1;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q;
    mode_e               mode_q;
    logic                dir_q, lsb_q, cpol_q, cpha_q;
    logic [DIV_W-1:0]    div_q;
    logic [1:0]          sh_q;
    logic [BW-1:0]       beats_m1_q, beat_q;
    logic [MAX_CHAR-1:0] tx_q, rx_q, rx_data_q;
    logic [3:0]          out_q;
    logic                rx_valid_q, cfg_err_q;

    logic                accept, legal, start, abort_run, final_edge, lead, trail;
    logic [1:0]          sh_in;
    logic [LEN_W-1:0]    lane_mask;
    logic [BW-1:0]       beats_m1_in;
    logic [MAX_CHAR-1:0] aligned, rx_next, rx_fin;
    logic [3:0]          lane_cnt, lanes_in;

    // Next L bits to put on the lanes, taken from the leading end of the shift register
    function automatic logic [3:0] beat_head(input logic [MAX_CHAR-1:0] d, input logic l,
                                             input logic [1:0] s);
        case (s)
            2'd0:    return l ? {3'b000, d[0]}   : {3'b000, d[MAX_CHAR-1]};
            2'd1:    return l ? {2'b00, d[1:0]}  : {2'b00, d[MAX_CHAR-1 -: 2]};
            default: return l ? d[3:0]           : d[MAX_CHAR-1 -: 4];
        endcase
    endfunction

    function automatic logic [MAX_CHAR-1:0] beat_shift(input logic [MAX_CHAR-1:0] d,
                                                       input logic l, input logic [1:0] s);
        logic [3:0] n;
        n = 4'd1 << s;
        return l ? (d >> n) : (d << n);
    endfunction

    assign accept      = tx_valid && tx_ready;
    assign sh_in       = lane_log2(mode);
    assign lane_mask   = LEN_W'((4'd1 << sh_in) - 4'd1);
    assign legal       = (mode != ModeRsvd) && ((len & lane_mask) == lane_mask);
    assign start       = accept && legal;
    assign beats_m1_in = (({1'b0, len} + BW'(1)) >> sh_in) - BW'(1);
    // MSB-first chars are left-justified so the shifter always drains from the top
    assign aligned     = lsb ? tx_data : (tx_data << (MAX_CHAR - 1 - 32'(len)));
    assign abort_run   = abort && (state_q == StRun);
    assign final_edge  = trail && (beat_q == beats_m1_q);

    assign lane_cnt = 4'd1 << sh_q;
    always_comb begin
        lanes_in = 4'b0000;
        unique case (mode_q)
            ModeSingle: lanes_in = {3'b000, sd_i[1]};
            ModeDual:   lanes_in = {2'b00, sd_i[1:0]};
            default:    lanes_in = sd_i;
        endcase
    end

    assign rx_next = lsb_q
        ? ((rx_q >> lane_cnt) | (MAX_CHAR'(lanes_in) << (MAX_CHAR - 32'(lane_cnt))))
        : ((rx_q << lane_cnt) | MAX_CHAR'(lanes_in));
    assign rx_fin  = cpha_q ? rx_next : rx_q;

    spi_shift_mlane_sclk_gen #(
        .DIV_W(DIV_W)
    ) u_sclk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept || abort_run),
        .load_lvl(accept ? cpol : cpol_q),
        .run     (state_q == StRun),
        .divider (div_q),
        .sclk_o  (sclk_o),
        .lead    (lead),
        .trail   (trail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun: begin
                if (abort)           state_d = StIdle;
                else if (final_edge) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_ready = (state_q == StIdle) && !rx_valid_q;
        tip      = (state_q == StRun);
        sd_oe    = 4'b0000;
        if (state_q == StRun) begin
            unique case (mode_q)
                ModeSingle: sd_oe = 4'b0001;
                ModeDual:   sd_oe = dir_q ? 4'b0000 : 4'b0011;
                ModeQuad:   sd_oe = dir_q ? 4'b0000 : 4'b1111;
                default:    sd_oe = 4'b0000;
            endcase
        end
        sd_o     = out_q & sd_oe;
        rx_valid = rx_valid_q;
        rx_data  = rx_data_q;
        cfg_err  = cfg_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            mode_q     <= ModeSingle;
            dir_q      <= 1'b0;
            lsb_q      <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            sh_q       <= 2'd0;
            beats_m1_q <= '0;
            beat_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            out_q      <= 4'b0000;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= accept && !legal;
            if (accept) begin
                len_q      <= len;
                mode_q     <= mode_e'(mode);
                dir_q      <= dir;
                lsb_q      <= lsb;
                cpol_q     <= cpol;
                cpha_q     <= cpha;
                div_q      <= divider;
                sh_q       <= sh_in;
                beats_m1_q <= beats_m1_in;
                beat_q     <= '0;
                rx_q       <= '0;
                // cpha=0 presents beat 0 before the first edge; cpha=1 shifts it out on it
                out_q      <= cpha ? 4'b0000 : beat_head(aligned, lsb, sh_in);
                tx_q       <= cpha ? aligned : beat_shift(aligned, lsb, sh_in);
            end else if (state_q == StRun) begin
                if (lead) begin
                    if (cpha_q) begin
                        out_q <= beat_head(tx_q, lsb_q, sh_q);
                        tx_q  <= beat_shift(tx_q, lsb_q, sh_q);
                    end else begin
                        rx_q <= rx_next;
                    end
                end
                if (trail) begin
                    beat_q <= beat_q + BW'(1);
                    if (cpha_q) begin
                        rx_q <= rx_next;
                    end else if (!final_edge) begin
                        out_q <= beat_head(tx_q, lsb_q, sh_q);
                        tx_q  <= beat_shift(tx_q, lsb_q, sh_q);
                    end
                end
                if (final_edge && !abort) begin
                    if (mode_q == ModeSingle || dir_q) begin
                        rx_data_q <= lsb_q ? (rx_fin >> (MAX_CHAR - 1 - 32'(len_q))) : rx_fin;
                    end else begin
                        rx_data_q <= '0;
                    end
                end
            end

            if (state_q == StRun && final_edge && !abort) rx_valid_q <= 1'b1;
            else if (rx_valid_q && rx_ready)               rx_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_shift_mlane.sv
// Directed bench for spi_shift_mlane: expected chars are queued at request time and
// compared when the DUT presents rx_valid.
module tb_spi_shift_mlane;

    localparam int unsigned MAX_CHAR = 32;
    localparam int unsigned LEN_W    = 5;
    localparam int unsigned DIV_W    = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                tx_valid, tx_ready;
    logic [MAX_CHAR-1:0] tx_data;
    logic [LEN_W-1:0]    len;
    logic [1:0]          mode;
    logic                dir, lsb, cpol, cpha, abort;
    logic [DIV_W-1:0]    divider;
    logic                rx_valid, rx_ready;
    logic [MAX_CHAR-1:0] rx_data;
    logic                cfg_err, tip, sclk_o;
    logic [3:0]          sd_o, sd_oe, sd_i, sd_drv;
    logic                loop_en;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Single-mode loopback: MOSI lane 0 feeds MISO on sd_i[1]
    assign sd_i = loop_en ? {2'b00, sd_o[0], 1'b0} : sd_drv;

    spi_shift_mlane #(
        .MAX_CHAR(MAX_CHAR),
        .LEN_W   (LEN_W),
        .DIV_W   (DIV_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .len     (len),
        .mode    (mode),
        .dir     (dir),
        .lsb     (lsb),
        .cpol    (cpol),
        .cpha    (cpha),
        .divider (divider),
        .abort   (abort),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_data (rx_data),
        .cfg_err (cfg_err),
        .tip     (tip),
        .sclk_o  (sclk_o),
        .sd_o    (sd_o),
        .sd_oe   (sd_oe),
        .sd_i    (sd_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request; returns in cycle 1 (the first cycle after the accept edge)
    task automatic send(input logic [31:0] d, input logic [4:0] l, input logic [1:0] m,
                        input logic dr, input logic ls, input logic cp, input logic ch,
                        input logic [15:0] dv);
        int n = 0;
        while (!tx_ready && n < 200) begin
            step();
            n++;
        end
        check("tx_ready_before_send", tx_ready, 1'b1);
        tx_data  = d;
        len      = l;
        mode     = m;
        dir      = dr;
        lsb      = ls;
        cpol     = cp;
        cpha     = ch;
        divider  = dv;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = '1;
        len      = '0;
        mode     = 2'b11;
    endtask

    task automatic rx_pop(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=0x%0h expected=<empty scoreboard>", tag, rx_data);
        end else begin
            check(tag, rx_data, exp_q.pop_front());
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat[4];
        int n;
        pat = '{4'b1111, 4'b1100, 4'b1110, 4'b1101};
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; len = '0; mode = '0; dir = 1'b0;
        lsb = 1'b0; cpol = 1'b0; cpha = 1'b0; divider = '0; abort = 1'b0; rx_ready = 1'b0;
        sd_drv = 4'b0000; loop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 32'h0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_tip", tip, 1'b0);
        check("rst_sclk", sclk_o, 1'b0);
        check("rst_sd_o", sd_o, 4'h0);
        check("rst_sd_oe", sd_oe, 4'h0);
        rst_n = 1'b1;
        step();

        // Single, mode 0, D=0, MSB-first loopback; garbage above len must not leak
        loop_en = 1'b1;
        exp_q.push_back(32'hA5);
        send(32'h1234_56A5, 5'd7, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        check("t1_tip_c1", tip, 1'b1);
        check("t1_oe_c1", sd_oe, 4'b0001);
        check("t1_sdo_c1", sd_o, 4'b0001);
        check("t1_sclk_c1", sclk_o, 1'b0);
        step();
        check("t1_sclk_c2", sclk_o, 1'b1);
        repeat (14) step();
        check("t1_rxv_c16", rx_valid, 1'b0);
        check("t1_tip_c16", tip, 1'b1);
        step();
        check("t1_rxv_c17", rx_valid, 1'b1);
        check("t1_tip_c17", tip, 1'b0);
        check("t1_oe_c17", sd_oe, 4'h0);
        check("t1_sclk_c17", sclk_o, 1'b0);
        rx_pop("t1_rx_data");

        // Unread char stalls the next request
        tx_valid = 1'b1; tx_data = 32'h3C; len = 5'd7; mode = 2'b00;
        repeat (3) step();
        check("stall_tx_ready", tx_ready, 1'b0);
        check("stall_tip", tip, 1'b0);
        check("stall_rx_valid", rx_valid, 1'b1);
        tx_valid = 1'b0;
        consume();
        check("stall_rxv_cleared", rx_valid, 1'b0);
        check("stall_tx_ready_back", tx_ready, 1'b1);

        // Quad write, LSB-first, D=1: nibbles 4,3,2,1
        loop_en = 1'b0;
        exp_q.push_back(32'h0);
        send(32'h1234, 5'd15, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
        check("t2_oe", sd_oe, 4'b1111);
        step();
        check("t2_beat0", sd_o, 4'h4);
        for (int k = 1; k < 4; k++) begin
            repeat (4) step();
            check($sformatf("t2_beat%0d", k), sd_o, 4'(4 - k));
        end
        repeat (2) step();
        check("t2_rxv_c16", rx_valid, 1'b0);
        step();
        check("t2_rxv_c17", rx_valid, 1'b1);
        rx_pop("t2_rx_data");
        consume();

        // Dual read, MSB-first, cpol=1 cpha=1, D=0; sd_i[3:2] carry noise
        exp_q.push_back(32'hC9);
        send(32'hFF, 5'd7, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0);
        check("t3_sclk_c1", sclk_o, 1'b1);
        for (int c = 0; c < 8; c++) begin
            sd_drv = pat[c / 2];
            check($sformatf("t3_oe_c%0d", c + 1), sd_oe, 4'h0);
            step();
        end
        check("t3_rxv_c9", rx_valid, 1'b1);
        check("t3_sclk_done", sclk_o, 1'b1);
        rx_pop("t3_rx_data");
        consume();
        check("t3_sclk_idle", sclk_o, 1'b1);

        // Illegal configurations
        send(32'h0, 5'd6, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        check("t4_len6_cfg_err", cfg_err, 1'b1);
        check("t4_len6_tip", tip, 1'b0);
        step();
        check("t4_cfg_err_pulse", cfg_err, 1'b0);
        send(32'hFF, 5'd7, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        check("t4_mode11_cfg_err", cfg_err, 1'b1);
        check("t4_mode11_tip", tip, 1'b0);
        repeat (3) step();
        check("t4_no_rx", rx_valid, 1'b0);

        // Single, LSB-first, cpha=1, D=2, 12-bit char
        loop_en = 1'b1;
        exp_q.push_back(32'hABC);
        send(32'h000F_0ABC, 5'd11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
        n = 0;
        while (!rx_valid && n < 200) begin
            step();
            n++;
        end
        check("t5_latency", n, 72);
        rx_pop("t5_rx_data");
        consume();

        // Abort at cycle 5 of the run
        send(32'hA5, 5'd7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_tip", tip, 1'b0);
        check("t6_sclk", sclk_o, 1'b1);
        check("t6_oe", sd_oe, 4'h0);
        check("t6_tx_ready", tx_ready, 1'b1);
        repeat (20) step();
        check("t6_no_rx", rx_valid, 1'b0);

        // Asynchronous reset mid-run
        send(32'hA5, 5'd7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t7_tx_ready", tx_ready, 1'b1);
        check("t7_tip", tip, 1'b0);
        check("t7_sclk", sclk_o, 1'b0);
        check("t7_sd_o", sd_o, 4'h0);
        check("t7_sd_oe", sd_oe, 4'h0);
        check("t7_rx_valid", rx_valid, 1'b0);
        check("t7_rx_data", rx_data, 32'h0);
        check("t7_cfg_err", cfg_err, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
